// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width, memory responder state encoding and
// the bit positions of the control unit's memory strobes.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    localparam int STB_MARI  = 0;
    localparam int STB_MDRI  = 1;
    localparam int STB_MDRO  = 2;
    localparam int STB_READ  = 3;
    localparam int STB_WRITE = 4;
    localparam int STB_COUNT = 5;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read of the
// addressed word so the responder can capture it into MDR on the access edge.
module mem_array #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Store the write data when the responder performs a write access.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: holds MAR/MDR, sequences RAM accesses with a fixed
// number of wait states and returns a one-cycle done (and fault) pulse.
module mem_responder #(
    parameter int WORD_W      = cpu_pkg::WORD_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] bus_in,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_out_en,
    input  logic              mari,
    input  logic              mdri,
    input  logic              mdro,
    input  logic              read,
    input  logic              write,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    import cpu_pkg::*;

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    mem_state_t          state;
    logic [WORD_W-1:0]   mar;
    logic [WORD_W-1:0]   mdr;
    logic [3:0]          cnt;
    logic                fault_q;

    // Request captured at the sampling edge, so a same-cycle MAR/MDR load
    // does not change the access that was asked for.
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_write;
    logic [WORD_W-1:0]   acc_wdata;
    logic                acc_fault;

    logic [STB_COUNT-1:0] strobes;
    logic                 req;
    logic                 mar_fault;
    logic                 access_en;
    logic                 access_write;
    logic [IDX_W-1:0]     access_idx;
    logic [WORD_W-1:0]    access_wdata;
    logic [WORD_W-1:0]    ram_rdata;
    logic                 ram_we;

    assign strobes   = {write, read, mdro, mdri, mari};
    assign req       = (state == IDLE) && (strobes[STB_READ] || strobes[STB_WRITE]);
    assign mar_fault = |(mar >> IDX_W);

    // Select which access (if any) touches the RAM this cycle.
    always_comb begin
        access_en    = 1'b0;
        access_write = acc_write;
        access_idx   = acc_idx;
        access_wdata = acc_wdata;
        if (state == IDLE && WAIT_STATES == 0) begin
            access_en    = req && !mar_fault;
            access_write = !strobes[STB_READ] && strobes[STB_WRITE];
            access_idx   = mar[IDX_W-1:0];
            access_wdata = mdr;
        end else if (state == WAIT && cnt == 4'd1) begin
            access_en = !acc_fault;
        end
    end

    assign ram_we = access_en && access_write && !reset;

    mem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clock (clock),
        .we    (ram_we),
        .addr  (access_idx),
        .wdata (access_wdata),
        .rdata (ram_rdata)
    );

    // Access sequencer: register loads in IDLE, wait countdown, done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mar       <= '0;
            mdr       <= '0;
            cnt       <= '0;
            fault_q   <= 1'b0;
            acc_idx   <= '0;
            acc_write <= 1'b0;
            acc_wdata <= '0;
            acc_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fault_q <= 1'b0;
                    if (strobes[STB_MARI]) mar <= bus_in;
                    if (strobes[STB_MDRI]) mdr <= bus_in;
                    if (req) begin
                        acc_idx   <= mar[IDX_W-1:0];
                        acc_write <= !strobes[STB_READ] && strobes[STB_WRITE];
                        acc_wdata <= mdr;
                        acc_fault <= mar_fault;
                        if (WAIT_STATES == 0) begin
                            state   <= DONE;
                            fault_q <= mar_fault;
                            if (access_en && !access_write) mdr <= ram_rdata;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state   <= DONE;
                        fault_q <= acc_fault;
                        if (access_en && !access_write) mdr <= ram_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    fault_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign fault      = fault_q;
    assign bus_out_en = mdro;
    assign bus_out    = mdro ? mdr : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES=2 and 0).
module tb_mem_responder;

    localparam int W = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] bus_in = '0;
    logic [31:0] bus_out;
    logic        bus_out_en;
    logic        mari = 0, mdri = 0, mdro = 0, read = 0, write = 0;
    logic        busy, done, fault;

    logic [31:0] bus_in0 = '0;
    logic [31:0] bus_out0;
    logic        bus_out_en0;
    logic        mari0 = 0, mdri0 = 0, mdro0 = 0, read0 = 0, write0 = 0;
    logic        busy0, done0, fault0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_responder #(.WORD_W(32), .DEPTH(256), .WAIT_STATES(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_out_en (bus_out_en),
        .mari       (mari),
        .mdri       (mdri),
        .mdro       (mdro),
        .read       (read),
        .write      (write),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    mem_responder #(.WORD_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .bus_in     (bus_in0),
        .bus_out    (bus_out0),
        .bus_out_en (bus_out_en0),
        .mari       (mari0),
        .mdri       (mdri0),
        .mdro       (mdro0),
        .read       (read0),
        .write      (write0),
        .busy       (busy0),
        .done       (done0),
        .fault      (fault0)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m_ar, input logic m_dr, input logic rd,
                                 input logic wr, input logic [31:0] value);
        mari   = m_ar;
        mdri   = m_dr;
        read   = rd;
        write  = wr;
        bus_in = value;
    endtask

    task automatic loadMar(input logic [31:0] value);
        applyStimulus(1, 0, 0, 0, value);
        tick;
        applyStimulus(0, 0, 0, 0, '0);
    endtask

    task automatic loadMdr(input logic [31:0] value);
        applyStimulus(0, 1, 0, 0, value);
        tick;
        applyStimulus(0, 0, 0, 0, '0);
    endtask

    // Issue a request and stop in the cycle where done must be high.
    task automatic doAccess(input logic rd, input logic wr, input logic exp_fault,
                            input string tag);
        applyStimulus(0, 0, rd, wr, '0);
        tick;
        applyStimulus(0, 0, 0, 0, '0);
        for (int i = 1; i <= W; i++) begin
            checkOutput({tag, "_done_early"}, done, 1'b0);
            checkOutput({tag, "_busy"}, busy, 1'b1);
            tick;
        end
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_fault"}, fault, exp_fault);
    endtask

    initial begin
        $display("[TB] start");
        tick;
        tick;
        reset = 1'b0;

        // reset state over five idle cycles
        for (int i = 0; i < 5; i++) begin
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_done", done, 1'b0);
            checkOutput("rst_fault", fault, 1'b0);
            checkOutput("rst_bus_out", bus_out, 32'h0);
            tick;
        end
        mdro = 1'b1;
        #1;
        checkOutput("rst_mdr", bus_out, 32'h0);
        checkOutput("rst_bus_en", bus_out_en, 1'b1);
        mdro = 1'b0;
        #1;
        checkOutput("bus_en_off", bus_out_en, 1'b0);

        // write 0xDEADBEEF to 0x10
        loadMar(32'h10);
        loadMdr(32'hDEADBEEF);
        doAccess(0, 1, 0, "wr10");
        tick;
        checkOutput("wr10_done_end", done, 1'b0);
        checkOutput("wr10_busy_end", busy, 1'b0);

        // read back 0x10 with MDR cleared first
        loadMdr(32'h0);
        mdro = 1'b1;
        doAccess(1, 0, 0, "rd10");
        checkOutput("rd10_data", bus_out, 32'hDEADBEEF);
        checkOutput("rd10_en", bus_out_en, 1'b1);
        tick;
        checkOutput("rd10_done_end", done, 1'b0);

        // fault: MAR out of range leaves MDR alone
        loadMar(32'h100);
        doAccess(1, 0, 1, "flt");
        checkOutput("flt_mdr", bus_out, 32'hDEADBEEF);
        tick;
        checkOutput("flt_fault_end", fault, 1'b0);
        loadMar(32'h10);
        loadMdr(32'h0);
        doAccess(1, 0, 0, "flt_rd10");
        checkOutput("flt_rd10_data", bus_out, 32'hDEADBEEF);
        tick;

        // busy masking: strobes during WAIT of a write are ignored
        loadMdr(32'hDEADBEEF);
        applyStimulus(0, 0, 0, 1, '0);
        tick;
        applyStimulus(1, 1, 1, 1, 32'h20);
        checkOutput("mask_busy", busy, 1'b1);
        tick;
        applyStimulus(0, 0, 0, 0, 32'h1);
        checkOutput("mask_done_early", done, 1'b0);
        tick;
        checkOutput("mask_done", done, 1'b1);
        checkOutput("mask_mdr", bus_out, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput("mask_no_second_done", done, 1'b0);
        end
        loadMdr(32'h0);
        doAccess(1, 0, 0, "mask_rd");
        checkOutput("mask_rd_data", bus_out, 32'hDEADBEEF);
        tick;

        // read and write together: read wins
        loadMdr(32'h5);
        doAccess(1, 1, 0, "rw");
        checkOutput("rw_data", bus_out, 32'hDEADBEEF);
        tick;
        loadMdr(32'h0);
        doAccess(1, 0, 0, "rw_chk");
        checkOutput("rw_ram", bus_out, 32'hDEADBEEF);
        tick;

        // reset during WAIT drops the pending write
        loadMar(32'h30);
        loadMdr(32'hA5A5A5A5);
        doAccess(0, 1, 0, "pre30");
        tick;
        loadMdr(32'h12345678);
        applyStimulus(0, 0, 0, 1, '0);
        tick;
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("rstw_busy", busy, 1'b1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rstw_no_done", done, 1'b0);
            checkOutput("rstw_idle", busy, 1'b0);
            tick;
        end
        checkOutput("rstw_mdr_cleared", bus_out, 32'h0);
        loadMar(32'h30);
        doAccess(1, 0, 0, "rd30");
        checkOutput("rd30_data", bus_out, 32'hA5A5A5A5);
        tick;
        mdro = 1'b0;

        // zero wait states: done one cycle after the request
        mari0 = 1; bus_in0 = 32'h7;
        tick;
        mari0 = 0; mdri0 = 1; bus_in0 = 32'h0BADF00D;
        tick;
        mdri0 = 0; write0 = 1;
        tick;
        write0 = 0;
        checkOutput("w0_wr_done", done0, 1'b1);
        checkOutput("w0_wr_fault", fault0, 1'b0);
        tick;
        checkOutput("w0_wr_done_end", done0, 1'b0);
        mdri0 = 1; bus_in0 = 32'h0;
        tick;
        mdri0 = 0; mdro0 = 1; read0 = 1;
        #1;
        checkOutput("w0_mdr_cleared", bus_out0, 32'h0);
        tick;
        read0 = 0;
        checkOutput("w0_rd_done", done0, 1'b1);
        checkOutput("w0_rd_data", bus_out0, 32'h0BADF00D);
        tick;
        checkOutput("w0_rd_done_end", done0, 1'b0);
        checkOutput("w0_rd_busy_end", busy0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
